mpmc11_cmd_issue: RTL and testbench

MPMC11_CMD_ISSUE -- requirements
Module: mpmc11_cmd_issue

---
 rtl/mpmc11_cmd_issue.sv | 149 ++++++++++++++
 tb/tb_mpmc11_cmd_issue.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpmc11_cmd_issue.sv
// Burst command issuer for a DRAM app interface: walks 32-byte strips,
// pairs write data with commands, and counts read returns with a watchdog.
module mpmc11_cmd_issue #(
    parameter int unsigned TMO = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic         we,
    input  logic [31:0]  addr_base,
    input  logic [5:0]   num_strips,
    output logic         app_en,
    output logic [2:0]   app_cmd,
    output logic [31:0]  app_addr,
    input  logic         app_rdy,
    output logic         app_wdf_wren,
    output logic         app_wdf_end,
    output logic [255:0] app_wdf_data,
    output logic [31:0]  app_wdf_mask,
    input  logic         app_wdf_rdy,
    input  logic [255:0] wr_data,
    input  logic [31:0]  wr_mask,
    output logic [5:0]   wr_strip,
    input  logic         app_rd_data_valid,
    output logic [5:0]   rd_strip,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int unsigned CNT_W = 7;
    localparam int unsigned WD_W  = (TMO < 2) ? 1 : $clog2(TMO);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic             we_q;
    logic [CNT_W-1:0] n_q;
    logic [31:0]      cmd_addr;
    logic [CNT_W-1:0] cmd_cnt;
    logic [CNT_W-1:0] dat_cnt;
    logic [CNT_W-1:0] ret_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic             err_q;

    logic             cmd_hs;
    logic             dat_hs;
    logic             ret_inc;
    logic [CNT_W-1:0] cmd_cnt_nx;
    logic [CNT_W-1:0] dat_cnt_nx;
    logic [CNT_W-1:0] ret_cnt_nx;
    logic             unused_addr_lsb;

    // Interface outputs are decoded from registered state only (data passes through).
    assign app_en       = (state == ISSUE) && (cmd_cnt < n_q);
    assign app_cmd      = we_q ? 3'b000 : 3'b001;
    assign app_addr     = cmd_addr;
    assign app_wdf_wren = (state == ISSUE) && we_q && (dat_cnt < n_q);
    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_data = wr_data;
    assign app_wdf_mask = wr_mask;
    assign wr_strip     = dat_cnt[5:0];
    assign rd_strip     = ret_cnt[5:0];
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign err          = err_q;

    assign unused_addr_lsb = ^addr_base[4:0];

    // Returns only count inside an active read burst and never past n.
    assign cmd_hs     = app_en & app_rdy;
    assign dat_hs     = app_wdf_wren & app_wdf_rdy;
    assign ret_inc    = ((state == ISSUE) || (state == DRAIN)) && !we_q
                        && app_rd_data_valid && (ret_cnt < n_q);
    assign cmd_cnt_nx = cmd_cnt + CNT_W'(cmd_hs);
    assign dat_cnt_nx = dat_cnt + CNT_W'(dat_hs);
    assign ret_cnt_nx = ret_cnt + CNT_W'(ret_inc);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            n_q      <= '0;
            cmd_addr <= '0;
            cmd_cnt  <= '0;
            dat_cnt  <= '0;
            ret_cnt  <= '0;
            wd_cnt   <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state    <= ISSUE;
                        we_q     <= we;
                        n_q      <= (num_strips == 6'd0) ? CNT_W'(1) : {1'b0, num_strips};
                        cmd_addr <= {addr_base[31:5], 5'h00};
                        cmd_cnt  <= '0;
                        dat_cnt  <= '0;
                        ret_cnt  <= '0;
                        wd_cnt   <= '0;
                        err_q    <= 1'b0;
                    end
                end
                ISSUE: begin
                    cmd_cnt <= cmd_cnt_nx;
                    dat_cnt <= dat_cnt_nx;
                    ret_cnt <= ret_cnt_nx;
                    if (cmd_hs) begin
                        cmd_addr <= cmd_addr + 32'h20;
                    end
                    if (we_q) begin
                        if ((cmd_cnt_nx == n_q) && (dat_cnt_nx == n_q)) begin
                            state <= DONE;
                        end
                    end else if (cmd_cnt_nx == n_q) begin
                        state  <= (ret_cnt_nx == n_q) ? DONE : DRAIN;
                        wd_cnt <= '0;
                    end
                end
                DRAIN: begin
                    ret_cnt <= ret_cnt_nx;
                    if (ret_cnt_nx == n_q) begin
                        state <= DONE;
                    end else if (app_rd_data_valid) begin
                        wd_cnt <= '0;
                    end else if (wd_cnt == WD_W'(TMO - 1)) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpmc11_cmd_issue.sv
// Scoreboard bench for mpmc11_cmd_issue: expected commands and data beats are
// queued when a burst is launched and popped as the DUT hands them off.
module tb_mpmc11_cmd_issue;

    localparam int unsigned TMO = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req = 1'b0;
    logic         we = 1'b0;
    logic [31:0]  addr_base = '0;
    logic [5:0]   num_strips = '0;
    logic         app_en;
    logic [2:0]   app_cmd;
    logic [31:0]  app_addr;
    logic         app_rdy = 1'b0;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic [255:0] app_wdf_data;
    logic [31:0]  app_wdf_mask;
    logic         app_wdf_rdy = 1'b0;
    logic [255:0] wr_data;
    logic [31:0]  wr_mask;
    logic [5:0]   wr_strip;
    logic         app_rd_data_valid = 1'b0;
    logic [5:0]   rd_strip;
    logic         busy;
    logic         done;
    logic         err;

    int checks = 0;
    int failures = 0;
    int cmd_hs_cnt = 0;
    int beat_cnt = 0;
    int done_cnt = 0;

    logic [34:0] exp_cmd[$];
    logic [5:0]  exp_strip[$];
    logic [34:0] mon_cmd;
    logic [5:0]  mon_strip;
    logic        prev_pending = 1'b0;
    logic [31:0] prev_addr = '0;

    mpmc11_cmd_issue #(.TMO(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr_base(addr_base), .num_strips(num_strips),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_rdy(app_wdf_rdy), .wr_data(wr_data), .wr_mask(wr_mask),
        .wr_strip(wr_strip), .app_rd_data_valid(app_rd_data_valid),
        .rd_strip(rd_strip), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Write-data source keyed by the requested strip index.
    always_comb begin
        wr_data = {8{32'hC0DE_0000 | 32'(wr_strip)}};
        wr_mask = 32'hFFFF_0000 ^ 32'(wr_strip);
    end

    // Handshake monitor on the falling edge, where all DUT outputs are settled.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_pending) begin
                checks++;
                if (app_en !== 1'b1 || app_addr !== prev_addr) begin
                    failures++;
                    $display("FAIL cmd_hold: app_en=%b app_addr=%h, required app_en=1 app_addr=%h",
                             app_en, app_addr, prev_addr);
                end
            end
            if (app_en && app_rdy) begin
                cmd_hs_cnt++;
                checks++;
                if (exp_cmd.size() == 0) begin
                    failures++;
                    $display("FAIL cmd_unexpected: cmd=%b addr=%h, required no command", app_cmd, app_addr);
                end else begin
                    mon_cmd = exp_cmd.pop_front();
                    if ({app_cmd, app_addr} !== mon_cmd) begin
                        failures++;
                        $display("FAIL cmd: cmd=%b addr=%h, required cmd=%b addr=%h",
                                 app_cmd, app_addr, mon_cmd[34:32], mon_cmd[31:0]);
                    end
                end
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                beat_cnt++;
                checks++;
                if (exp_strip.size() == 0) begin
                    failures++;
                    $display("FAIL beat_unexpected: wr_strip=%0d, required no data beat", wr_strip);
                end else begin
                    mon_strip = exp_strip.pop_front();
                    if (wr_strip !== mon_strip || app_wdf_end !== 1'b1
                        || app_wdf_data !== {8{32'hC0DE_0000 | 32'(mon_strip)}}
                        || app_wdf_mask !== (32'hFFFF_0000 ^ 32'(mon_strip))) begin
                        failures++;
                        $display("FAIL beat: wr_strip=%0d end=%b data[31:0]=%h mask=%h, required strip=%0d end=1 data[31:0]=%h mask=%h",
                                 wr_strip, app_wdf_end, app_wdf_data[31:0], app_wdf_mask, mon_strip,
                                 32'hC0DE_0000 | 32'(mon_strip), 32'hFFFF_0000 ^ 32'(mon_strip));
                    end
                end
            end
            if (done) done_cnt++;
            prev_pending = app_en && !app_rdy;
            prev_addr    = app_addr;
        end else begin
            prev_pending = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic w, input logic [31:0] a, input logic [5:0] ns);
        tick();
        req = 1'b1; we = w; addr_base = a; num_strips = ns;
        tick();
        req = 1'b0;
    endtask

    task automatic push_burst(input logic w, input logic [31:0] a, input int n);
        logic [31:0] base;
        base = {a[31:5], 5'h00};
        for (int i = 0; i < n; i++) begin
            exp_cmd.push_back({(w ? 3'b000 : 3'b001), base});
            if (w) exp_strip.push_back(6'(i));
            base = base + 32'h20;
        end
    endtask

    task automatic wait_done(input int max_cyc, output bit ok, output int cyc);
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            cyc = i + 1;
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({app_en, app_wdf_wren, busy, done, err} !== 5'b0 || app_addr !== 32'h0
            || rd_strip !== 6'd0 || wr_strip !== 6'd0) begin
            failures++;
            $display("FAIL reset: en=%b wren=%b busy=%b done=%b err=%b addr=%h, required all zero",
                     app_en, app_wdf_wren, busy, done, err, app_addr);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_basic();
        app_rdy = 1'b1; app_rd_data_valid = 1'b0;
        cmd_hs_cnt = 0; done_cnt = 0;
        exp_cmd.push_back({3'b001, 32'h0000_1220});
        exp_cmd.push_back({3'b001, 32'h0000_1240});
        exp_cmd.push_back({3'b001, 32'h0000_1260});
        exp_cmd.push_back({3'b001, 32'h0000_1280});
        start_burst(1'b0, 32'h0000_1234, 6'd4);
        for (int i = 0; i < 20 && exp_cmd.size() != 0; i++) tick();
        checks++;
        if (cmd_hs_cnt != 4 || busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL read_issue: cmds=%0d busy=%b done=%b, required cmds=4 busy=1 done=0",
                     cmd_hs_cnt, busy, done);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (rd_strip !== 6'(i) || done !== 1'b0) begin
                failures++;
                $display("FAIL read_strip: rd_strip=%0d done=%b, required %0d done=0", rd_strip, done, i);
            end
            app_rd_data_valid = 1'b1;
        end
        tick();
        app_rd_data_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL read_done: done=%b err=%b, required done=1 err=0", done, err);
        end
        tick(); tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || done_cnt != 1) begin
            failures++;
            $display("FAIL read_idle: done=%b busy=%b pulses=%0d, required 0 0 1", done, busy, done_cnt);
        end
    endtask

    task automatic test_rdy_toggle();
        bit ok;
        app_rdy = 1'b0;
        cmd_hs_cnt = 0; done_cnt = 0;
        push_burst(1'b0, 32'h4000_0010, 4);
        start_burst(1'b0, 32'h4000_0010, 6'd4);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            app_rdy = k[0];
            app_rd_data_valid = 1'b1;
            tick();
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL toggle_timeout: done=%b, required done within 40 cycles", done);
        end
        tick(); tick();
        checks++;
        if (cmd_hs_cnt != 4 || done_cnt != 1 || rd_strip !== 6'd4 || exp_cmd.size() != 0) begin
            failures++;
            $display("FAIL toggle_counts: cmds=%0d pulses=%0d rd_strip=%0d left=%0d, required 4 1 4 0",
                     cmd_hs_cnt, done_cnt, rd_strip, exp_cmd.size());
        end
        app_rd_data_valid = 1'b0; app_rdy = 1'b0;
    endtask

    task automatic test_write();
        bit ok;
        int cyc;
        app_rdy = 1'b0; app_wdf_rdy = 1'b1;
        cmd_hs_cnt = 0; beat_cnt = 0; done_cnt = 0;
        push_burst(1'b1, 32'h0000_2000, 3);
        start_burst(1'b1, 32'h0000_2000, 6'd3);
        tick(); tick();
        checks++;
        if (beat_cnt != 2 || cmd_hs_cnt != 0 || done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL write_lead: beats=%0d cmds=%0d done=%b busy=%b, required 2 0 0 1",
                     beat_cnt, cmd_hs_cnt, done, busy);
        end
        app_rdy = 1'b1;
        wait_done(20, ok, cyc);
        checks++;
        if (!ok || cmd_hs_cnt != 3 || beat_cnt != 3 || cyc != 3) begin
            failures++;
            $display("FAIL write_done: seen=%0d cyc=%0d cmds=%0d beats=%0d, required 1 3 3 3",
                     ok, cyc, cmd_hs_cnt, beat_cnt);
        end
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int cyc;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        cmd_hs_cnt = 0; beat_cnt = 0;
        push_burst(1'b1, 32'h0001_0040, 2);
        start_burst(1'b1, 32'h0001_0040, 6'd2);
        wait_done(20, ok, cyc);
        checks++;
        if (!ok || cyc != 2 || cmd_hs_cnt != 2 || beat_cnt != 2) begin
            failures++;
            $display("FAIL b2b_write: seen=%0d cyc=%0d cmds=%0d beats=%0d, required 1 2 2 2",
                     ok, cyc, cmd_hs_cnt, beat_cnt);
        end
        app_wdf_rdy = 1'b0;
        tick();
    endtask

    task automatic test_watchdog();
        bit ok;
        int cyc;
        app_rdy = 1'b1; app_rd_data_valid = 1'b0;
        push_burst(1'b0, 32'h0000_8000, 2);
        start_burst(1'b0, 32'h0000_8000, 6'd2);
        wait_done(200, ok, cyc);
        checks++;
        if (!ok || cyc != 2 + int'(TMO) || err !== 1'b1) begin
            failures++;
            $display("FAIL watchdog: seen=%0d cyc=%0d err=%b, required 1 %0d 1", ok, cyc, err, 2 + TMO);
        end
        tick();
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL err_sticky: err=%b busy=%b, required err=1 busy=0", err, busy);
        end
    endtask

    task automatic test_zero_and_wrap();
        bit ok;
        int cyc;
        app_rdy = 1'b1; app_rd_data_valid = 1'b1;
        cmd_hs_cnt = 0;
        push_burst(1'b0, 32'hDEAD_BEEF, 1);
        start_burst(1'b0, 32'hDEAD_BEEF, 6'd0);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear: err=%b, required 0 after req", err);
        end
        wait_done(20, ok, cyc);
        checks++;
        if (!ok || cmd_hs_cnt != 1 || cyc != 1) begin
            failures++;
            $display("FAIL zero_strips: seen=%0d cyc=%0d cmds=%0d, required 1 1 1", ok, cyc, cmd_hs_cnt);
        end
        cmd_hs_cnt = 0;
        push_burst(1'b0, 32'hFFFF_FFE0, 2);
        start_burst(1'b0, 32'hFFFF_FFE0, 6'd2);
        wait_done(20, ok, cyc);
        checks++;
        if (!ok || cmd_hs_cnt != 2 || exp_cmd.size() != 0) begin
            failures++;
            $display("FAIL addr_wrap: seen=%0d cmds=%0d left=%0d, required 1 2 0", ok, cmd_hs_cnt, exp_cmd.size());
        end
        app_rd_data_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        int cyc;
        app_rdy = 1'b1; app_rd_data_valid = 1'b0;
        cmd_hs_cnt = 0;
        push_burst(1'b0, 32'h0000_3000, 4);
        start_burst(1'b0, 32'h0000_3000, 6'd4);
        tick(); tick();
        rst = 1'b1; app_rdy = 1'b0;
        tick();
        checks++;
        if (app_en !== 1'b0 || busy !== 1'b0 || app_addr !== 32'h0 || cmd_hs_cnt != 2) begin
            failures++;
            $display("FAIL rst_mid: en=%b busy=%b addr=%h cmds=%0d, required 0 0 0 2",
                     app_en, busy, app_addr, cmd_hs_cnt);
        end
        rst = 1'b0;
        exp_cmd.delete();
        app_rdy = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (app_en !== 1'b0 || busy !== 1'b0 || cmd_hs_cnt != 2) begin
            failures++;
            $display("FAIL rst_no_resume: en=%b busy=%b cmds=%0d, required 0 0 2", app_en, busy, cmd_hs_cnt);
        end
        push_burst(1'b0, 32'h0000_5000, 1);
        app_rd_data_valid = 1'b1;
        start_burst(1'b0, 32'h0000_5000, 6'd1);
        wait_done(20, ok, cyc);
        checks++;
        if (!ok || cmd_hs_cnt != 3 || exp_cmd.size() != 0) begin
            failures++;
            $display("FAIL rst_fresh: seen=%0d cmds=%0d left=%0d, required 1 3 0", ok, cmd_hs_cnt, exp_cmd.size());
        end
        app_rd_data_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_rdy_toggle();
        test_write();
        test_back_to_back();
        test_watchdog();
        test_zero_and_wrap();
        test_reset_mid_burst();
        checks++;
        if (exp_cmd.size() != 0 || exp_strip.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: cmds_left=%0d beats_left=%0d, required 0 0",
                     exp_cmd.size(), exp_strip.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
